// File: rtl/move_input_conditioner.sv
// Turns four raw, bouncing direction buttons into single-cycle move pulses.
// Each pulse is issued only in a cycle where the downstream game FSM accepts it.
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic accept,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic busy
);

  localparam int unsigned NB = 4;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] db;
  logic [NB-1:0] db_prev;
  logic [NB-1:0] press;
  logic [NB-1:0] pick;
  logic [NB-1:0] dir;
  logic          fire;
  state_t        state;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizer plus one-cycle history of the debounced level.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1      <= '0;
      s2      <= '0;
      db_prev <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      db_prev <= db;
    end
  end

  // Per-button debouncer: any disagreement that is not sustained restarts the count.
  for (genvar i = 0; i < NB; i++) begin : g_db
    logic          lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (s2[i] != lvl) begin
        if (cnt == CNT_MAX) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign db[i] = lvl;
  end

  assign press = db & ~db_prev;

  // Fixed priority among simultaneous presses: up > down > left > right.
  always_comb begin
    pick = '0;
    if (press[0])      pick = 4'b0001;
    else if (press[1]) pick = 4'b0010;
    else if (press[2]) pick = 4'b0100;
    else if (press[3]) pick = 4'b1000;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      dir   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press != '0) begin
            dir   <= pick;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (accept) state <= LOCKOUT;
        end
        LOCKOUT: begin
          if (db == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse is gated by accept in the same cycle; the FSM leaves PENDING on that edge.
  assign fire  = (state == PENDING) && accept;
  assign up    = fire & dir[0];
  assign down  = fire & dir[1];
  assign left  = fire & dir[2];
  assign right = fire & dir[3];
  assign busy  = (state != IDLE);

endmodule
